pad_default_loader: RTL

PAD_DEFAULT_LOADER -- requirements
Module: pad_default_loader

---
 rtl/pad_default_loader.sv | 111 +++++++++++
 1 files changed

// File: rtl/pad_default_loader.sv
// Serial loader that shifts per-pad default configuration words into the pad control chain,
// then pulses serial_load; pads are held at tie levels until a load has completed.
module pad_default_loader #(
  parameter int unsigned NPADS   = 2,
  parameter int unsigned CFG_W   = 13,
  parameter int unsigned RST_CYC = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start,
  input  logic [NPADS*CFG_W-1:0] pad_defaults,
  output logic                   serial_resetn,
  output logic                   serial_clock,
  output logic                   serial_data,
  output logic                   serial_load,
  output logic                   pad_hold,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned NBITS = NPADS * CFG_W;
  localparam int unsigned BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned RC_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYC - 1);
  localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StChainRst,
    StShiftLo,
    StShiftHi,
    StLoad,
    StDone
  } state_e;

  state_e           state_q;
  logic [BIT_W-1:0] bit_idx_q;
  logic [RC_W-1:0]  rst_cnt_q;

  // Outputs are assigned on entry to each state so they are all flop outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= StIdle;
      bit_idx_q     <= '0;
      rst_cnt_q     <= '0;
      serial_resetn <= 1'b0;
      serial_clock  <= 1'b0;
      serial_data   <= 1'b0;
      serial_load   <= 1'b0;
      pad_hold      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      serial_load <= 1'b0;
      done        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          serial_resetn <= 1'b1;
          serial_clock  <= 1'b0;
          if (start) begin
            state_q       <= StChainRst;
            serial_resetn <= 1'b0;
            rst_cnt_q     <= '0;
            busy          <= 1'b1;
            pad_hold      <= 1'b1;
          end
        end
        StChainRst: begin
          if (rst_cnt_q == RC_LAST) begin
            state_q       <= StShiftLo;
            serial_resetn <= 1'b1;
            bit_idx_q     <= BIT_LAST;
            serial_data   <= pad_defaults[NBITS-1];
          end else begin
            rst_cnt_q <= rst_cnt_q + RC_ONE;
          end
        end
        StShiftLo: begin
          state_q      <= StShiftHi;
          serial_clock <= 1'b1;
        end
        StShiftHi: begin
          serial_clock <= 1'b0;
          if (bit_idx_q == '0) begin
            state_q     <= StLoad;
            serial_load <= 1'b1;
          end else begin
            // Next bit is presented together with the falling shift clock.
            state_q     <= StShiftLo;
            bit_idx_q   <= bit_idx_q - BIT_ONE;
            serial_data <= pad_defaults[bit_idx_q - BIT_ONE];
          end
        end
        StLoad: begin
          state_q  <= StDone;
          done     <= 1'b1;
          pad_hold <= 1'b0;
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
